// File: rtl/rcs_34bit_serial_pkg.sv
// rcs_pkg: shared declarations for the digit-serial ripple-borrow subtractor.
//   state_t   - controller state encoding (IDLE / BUSY / DONE)
//   ndig      - number of digits (clock cycles) needed for a WIDTH-bit operand
//   width_ok  - legality check: WIDTH must be a non-zero multiple of DIGIT
package rcs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digits processed per operation.
  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // True when the operand splits evenly into whole digits.
  function automatic bit width_ok(input int width, input int digit);
    return (digit > 32'sd0) && (width >= digit) && ((width % digit) == 32'sd0);
  endfunction

endpackage

// File: rtl/rcs_34bit_serial_full_subtractor.sv
// full_subtractor: one-bit subtractor cell computing i_bit1 - i_bit2 - i_borrow.
// Ports:
//   i_bit1   minuend bit
//   i_bit2   subtrahend bit
//   i_borrow borrow in from the next-lower bit
//   o_diff   difference bit
//   o_borrow borrow out to the next-higher bit
module full_subtractor (
  input  logic i_bit1,
  input  logic i_bit2,
  input  logic i_borrow,
  output logic o_diff,
  output logic o_borrow
);

  assign o_diff   = i_bit1 ^ i_bit2 ^ i_borrow;
  // Borrow when 0-1, or when the bits are equal and a borrow arrives.
  assign o_borrow = (~i_bit1 & i_bit2) | (~(i_bit1 ^ i_bit2) & i_borrow);

endmodule

// File: rtl/rcs_34bit_serial.sv
// rcs_34bit_serial: digit-serial ripple-borrow subtractor.
// Subtracts two unsigned WIDTH-bit operands DIGIT bits per clock and returns
// {borrow_out, difference}, i.e. the low WIDTH+1 bits of {0,a} - {0,b}.
// Ports:
//   i_clk        clock, rising-edge
//   i_rst        asynchronous active-high reset
//   i_valid      operands valid (sampled only in IDLE)
//   o_ready      ready for operands (high only in IDLE)
//   i_sub_term1  minuend a
//   i_sub_term2  subtrahend b
//   o_valid      result valid (high only in DONE)
//   i_ready      downstream accepts the result
//   o_result     {borrow_out, difference}
module rcs_34bit_serial
  import rcs_pkg::*;
#(
  parameter int WIDTH = 34,
  parameter int DIGIT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_sub_term1,
  input  logic [WIDTH-1:0] i_sub_term2,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result
);

  localparam int NDIG  = ndig(WIDTH, DIGIT);
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_width
    $error("rcs_34bit_serial: WIDTH must be a multiple of DIGIT");
  end

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   sh_a;
  logic [WIDTH-1:0]   sh_b;
  logic [WIDTH-1:0]   diff;
  logic               brw;
  logic [CNT_W-1:0]   cnt;

  // Borrow chain across the digit: chain_brw[k] feeds cell k.
  logic [DIGIT:0]     chain_brw;
  logic [DIGIT-1:0]   dig_diff;

  assign chain_brw[0] = brw;

  for (genvar k = 0; k < DIGIT; k++) begin : g_cell
    full_subtractor u_fs (
      .i_bit1   (sh_a[k]),
      .i_bit2   (sh_b[k]),
      .i_borrow (chain_brw[k]),
      .o_diff   (dig_diff[k]),
      .o_borrow (chain_brw[k+1])
    );
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; the final digit is processed on the cnt == NDIG-1 edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_valid) begin
          state_next = BUSY;
        end else begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        if (cnt == LAST_CNT) begin
          state_next = DONE;
        end else begin
          state_next = BUSY;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (state)
      IDLE:    o_ready = 1'b1;
      BUSY:    o_ready = 1'b0;
      DONE:    o_valid = 1'b1;
      default: o_ready = 1'b0;
    endcase
  end

  // Operand load, digit-serial subtraction and result accumulation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sh_a <= '0;
      sh_b <= '0;
      diff <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            sh_a <= i_sub_term1;
            sh_b <= i_sub_term2;
            brw  <= 1'b0;
            cnt  <= '0;
          end
        end
        BUSY: begin
          sh_a <= sh_a >> DIGIT;
          sh_b <= sh_b >> DIGIT;
          // New digit enters at the top; after NDIG digits bit i sits at diff[i].
          diff <= {dig_diff, diff[WIDTH-1:DIGIT]};
          brw  <= chain_brw[DIGIT];
          cnt  <= cnt + 1'b1;
        end
        DONE: begin
          brw <= brw;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  assign o_result = {brw, diff};

endmodule

// File: tb/tb_rcs_34bit_serial.sv
// Self-checking bench for rcs_34bit_serial: directed vector table, reset corner
// cases, and randomized operands against an arithmetic reference.
module tb_rcs_34bit_serial;

  localparam int WIDTH = 34;
  localparam int NDIG  = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid;
  logic              i_ready;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic              o_ready;
  logic              o_valid;
  logic [WIDTH:0]    o_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rcs_34bit_serial #(.WIDTH(WIDTH), .DIGIT(2)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_sub_term1 (op_a),
    .i_sub_term2 (op_b),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   exp;
    int               hold;
    bit               noise;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: unsigned subtraction widened by one bit.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] wa;
    logic [WIDTH:0] wb;
    wa = {1'b0, a};
    wb = {1'b0, b};
    return wa - wb;
  endfunction

  function automatic logic [WIDTH-1:0] rnd34();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[WIDTH-1:0];
  endfunction

  // Runs one operation; called #1 after a rising edge.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int hold, input bit noise, output logic [WIDTH:0] res);
    int n;
    int lat;
    n = 0;
    while (!o_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_before_accept", o_ready, 1);
    i_valid = 1'b1;
    op_a    = a;
    op_b    = b;
    @(posedge clk); #1;
    check("ready_after_accept", o_ready, 0);
    lat = 0;
    while (!o_valid && lat < 100) begin
      i_valid = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      op_a    = rnd34();
      op_b    = rnd34();
      @(posedge clk); #1;
      lat++;
      if (!o_valid) check("ready_busy", o_ready, 0);
    end
    check("latency", lat, NDIG);
    check("ready_done", o_ready, 0);
    res = o_result;
    for (int h = 0; h < hold; h++) begin
      i_valid = noise ? 1'b1 : 1'b0;
      op_a    = rnd34();
      op_b    = rnd34();
      @(posedge clk); #1;
      check("valid_held", o_valid, 1);
      check("result_stable", o_result, res);
      check("ready_held_low", o_ready, 0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    check("valid_after_release", o_valid, 0);
    check("ready_after_release", o_ready, 1);
  endtask

  initial begin
    logic [WIDTH:0] res;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    vecs[0] = '{a: 34'd5,            b: 34'd3,            exp: 35'h0_0000_0002, hold: 0, noise: 1'b0};
    vecs[1] = '{a: 34'd0,            b: 34'd1,            exp: 35'h7_FFFF_FFFF, hold: 0, noise: 1'b0};
    vecs[2] = '{a: 34'h2_0000_0000,  b: 34'd1,            exp: 35'h1_FFFF_FFFF, hold: 1, noise: 1'b0};
    vecs[3] = '{a: 34'h3_FFFF_FFFF,  b: 34'h3_FFFF_FFFF,  exp: 35'h0,           hold: 0, noise: 1'b0};
    vecs[4] = '{a: 34'h3_FFFF_FFFF,  b: 34'd0,            exp: 35'h3_FFFF_FFFF, hold: 0, noise: 1'b0};
    vecs[5] = '{a: 34'h1_0000_0001,  b: 34'd2,            exp: 35'h0_FFFF_FFFF, hold: 5, noise: 1'b1};

    rst     = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    op_a    = '0;
    op_b    = '0;
    #23 rst = 1'b0;
    @(posedge clk); #1;
    check("reset_ready", o_ready, 1);
    check("reset_valid", o_valid, 0);
    check("reset_result", o_result, 0);

    // Directed table, applied back to back.
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].noise, res);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
    end

    // Asynchronous reset in the middle of BUSY (cnt == 8).
    i_valid = 1'b1;
    op_a    = 34'd0;
    op_b    = 34'd1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midreset_ready", o_ready, 1);
    check("midreset_valid", o_valid, 0);
    check("midreset_result", o_result, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("postreset_valid", o_valid, 0);
    do_op(34'd10, 34'd20, 0, 1'b0, res);
    check("after_reset_op", res, 35'h7_FFFF_FFF6);

    // Randomized operands with corner-biased picks.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(5, 0))
        0:       ra = '0;
        1:       ra = '1;
        default: ra = rnd34();
      endcase
      case ($urandom_range(5, 0))
        0:       rb = '0;
        1:       rb = '1;
        2:       rb = ra;
        default: rb = rnd34();
      endcase
      do_op(ra, rb, $urandom_range(2, 0), 1'($urandom_range(1, 0)), res);
      check("random_result", res, model(ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rcs_34bit_serial.md
# rcs_34bit_serial

Digit-serial ripple-borrow subtractor, the subtract-direction counterpart of the 34-bit ripple-carry adder in the adder test batch.
- Accepts two unsigned 34-bit operands through a valid/ready handshake.
- Ripples the borrow through a chain of DIGIT full-subtractor cells, DIGIT bits per clock.
- Returns {borrow_out, difference} through a second valid/ready handshake.
- Adds a registered, area-reduced subtractor class to the classification dataset.

## Interface
Parameters:
- WIDTH, 34, operand width; must be a multiple of DIGIT.
- DIGIT, 2, bits processed per cycle (full-subtractor cells in the chain).

Ports (clock and reset first):
- i_clk  input  1  single clock; all state updates on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  operands valid.
- o_ready  output  1  block can accept operands (high only in IDLE).
- i_sub_term1  input  WIDTH  minuend a, unsigned.
- i_sub_term2  input  WIDTH  subtrahend b, unsigned.
- o_valid  output  1  result valid (high only in DONE).
- i_ready  input  1  downstream accepts result.
- o_result  output  WIDTH+1  {borrow_out, difference}.

## Operation
- NDIG = WIDTH/DIGIT (17 by default).
- Internal registers:
  - operand shift registers sh_a, sh_b (WIDTH bits each).
  - difference register diff (WIDTH bits).
  - borrow register brw (1 bit).
  - digit counter cnt (width clog2(NDIG)).
- Arithmetic:
  - Result equals the low WIDTH+1 bits of {1'b0,a} - {1'b0,b}.
  - o_result[WIDTH] = 1 iff a < b.
  - o_result[WIDTH-1:0] = (a - b) mod 2^WIDTH.
- State machine with states IDLE, BUSY, DONE:
  - IDLE:
    - o_ready=1.
    - On i_valid && o_ready: load sh_a <= a, sh_b <= b, brw <= 0, cnt <= 0; go to BUSY.
  - BUSY:
    - Feed the DIGIT LSBs of sh_a/sh_b and brw into the subtractor chain. Cell k takes bit k and the borrow from cell k-1; cell 0 takes brw.
    - Shift sh_a/sh_b right by DIGIT.
    - Shift the chain's DIGIT difference bits into diff from the MSB end, so after NDIG digits bit i lands at diff[i].
    - brw <= borrow out of the last cell; cnt++.
    - When cnt == NDIG-1, go to DONE.
  - DONE:
    - o_valid=1, o_result = {brw, diff}, held stable.
    - On i_valid... is ignored; on i_ready go to IDLE.
- i_valid is ignored in BUSY and DONE; changes to the operand inputs after acceptance have no effect.
- o_ready and o_valid are decoded directly from the state register, with no combinational path from inputs.
- Reset, asynchronous and effective at any time including mid-BUSY:
  - State IDLE; sh_a, sh_b, diff, brw and cnt cleared.
  - Outputs: o_ready=1, o_valid=0, o_result=0.
  - An in-flight operation is discarded, with no partial result.

## Timing
- Latency: o_valid rises exactly NDIG rising edges after the accepting edge (17 by default).
- Throughput: at most one operation per NDIG+2 cycles (accept cycle in IDLE, NDIG BUSY cycles, at least one DONE cycle).
- Backpressure: DONE is held indefinitely while i_ready=0. The result is released on the edge where o_valid && i_ready, with IDLE (o_ready=1) in the next cycle.
- A new operation cannot be accepted in the same cycle a result is released.
- Critical path: DIGIT full-subtractor cells plus shift/mux; independent of WIDTH.

## Structure
- Shared package rcs_pkg holds:
  - typedef enum for the state: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - the NDIG derivation function.
  - the WIDTH % DIGIT == 0 elaboration check.
- Sub-module full_subtractor, pin-compatible in style with full_adder. Ports: i_bit1, i_bit2, i_borrow, o_diff, o_borrow.
  - o_diff = i_bit1 ^ i_bit2 ^ i_borrow.
  - o_borrow = (~i_bit1 & i_bit2) | (~(i_bit1 ^ i_bit2) & i_borrow).
- DIGIT instances of full_subtractor in a generate loop; the FSM, shift registers and counter sit in the top module.

## Test plan
1. Assert then deassert i_rst, no stimulus -> o_ready=1, o_valid=0, o_result=35'h0.
2. a=5, b=3 -> o_valid exactly 17 edges after accept, o_result=35'h0_0000_0002.
3. a=0, b=1 -> o_result=35'h7_FFFF_FFFF (borrow 1, diff all ones). Then a=34'h2_0000_0000, b=1 -> 35'h1_FFFF_FFFF (borrow ripples through all 17 digits).
4. a=b=34'h3_FFFF_FFFF -> o_result=0. Back-to-back with a=34'h3_FFFF_FFFF, b=0 -> 35'h3_FFFF_FFFF. o_ready low throughout BUSY/DONE.
5. Hold i_ready=0 for 5 cycles after o_valid; pulse i_valid with new operands during BUSY and DONE -> o_result stable, o_valid held, pulses ignored. The result releases on the first i_ready cycle and o_ready=1 in the next cycle.
6. Assert i_rst asynchronously (mid-cycle) while cnt=8 -> outputs return to reset values without waiting for a clock edge. Next op a=10, b=20 -> o_result=35'h7_FFFF_FFF6.
